// File: rtl/leds_racer_pkg.sv
// Shared constants for the LED racer track: GRB pixel layout, WS2812 timing
// defaults at 50 MHz, player colours and the frame encoder state encoding.
package leds_racer_pkg;

  localparam int PIXEL_W   = 24;
  localparam int GRB_G_MSB = 23;
  localparam int GRB_R_MSB = 15;
  localparam int GRB_B_MSB = 7;

  localparam int WS_NUM_LEDS  = 109;
  localparam int WS_T0H_CYC   = 20;
  localparam int WS_T1H_CYC   = 40;
  localparam int WS_BIT_CYC   = 63;
  localparam int WS_RESET_CYC = 3000;
  localparam int WS_STALL_MAX = 1000;

  localparam logic [PIXEL_W-1:0] COLOUR_OFF = 24'h000000;
  localparam logic [PIXEL_W-1:0] COLOUR_P1  = 24'h00FF00;  // red
  localparam logic [PIXEL_W-1:0] COLOUR_P2  = 24'h0000FF;  // blue

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_LATCH
  } enc_state_e;

  function automatic logic [PIXEL_W-1:0] grb(input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b);
    return {g, r, b};
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Times one WS2812 bit period: line high for T0H/T1H cycles, low for the rest,
// with bit_end on the last cycle. Free-runs back to back while i_go stays high.
module ws2812_bit_timer #(
  parameter int T0H_CYC = 20,
  parameter int T1H_CYC = 40,
  parameter int BIT_CYC = 63
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_go,
  input  logic i_bit,
  output logic o_line,
  output logic o_bit_end
);

  localparam int CW = $clog2(BIT_CYC);

  logic [CW-1:0] r_cyc;
  logic [CW-1:0] w_high_cyc;
  logic          w_bit_end;

  assign w_high_cyc = i_bit ? CW'(T1H_CYC) : CW'(T0H_CYC);
  assign w_bit_end  = i_go && (r_cyc == CW'(BIT_CYC - 1));
  assign o_line     = i_go && (r_cyc < w_high_cyc);
  assign o_bit_end  = w_bit_end;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc <= '0;
    end else if (!i_go || w_bit_end) begin
      r_cyc <= '0;
    end else begin
      r_cyc <= r_cyc + CW'(1);
    end
  end

endmodule

// File: rtl/ws2812_frame_encoder.sv
// Pulls a frame of GRB pixels through a one-entry buffer and serialises them
// gap-free onto the WS2812 line, then holds the line low for the latch period.
module ws2812_frame_encoder
  import leds_racer_pkg::*;
#(
  parameter int NUM_LEDS  = WS_NUM_LEDS,
  parameter int T0H_CYC   = WS_T0H_CYC,
  parameter int T1H_CYC   = WS_T1H_CYC,
  parameter int BIT_CYC   = WS_BIT_CYC,
  parameter int RESET_CYC = WS_RESET_CYC,
  parameter int STALL_MAX = WS_STALL_MAX
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [PIXEL_W-1:0]          pixel_data,
  input  logic                        pixel_valid,
  output logic                        pixel_ready,
  output logic [$clog2(NUM_LEDS)-1:0] pixel_index,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        underrun,
  output logic                        leds_line
);

  localparam int IW    = $clog2(NUM_LEDS);
  localparam int CNT_W = $clog2(NUM_LEDS + 1);
  localparam int SW    = $clog2(STALL_MAX + 1);
  localparam int RW    = $clog2(RESET_CYC + 1);

  enc_state_e         r_state, w_next_state;
  logic [PIXEL_W-1:0] r_buf, r_shifter;
  logic               r_buf_full;
  logic [CNT_W-1:0]   r_req_cnt, r_sent_cnt;
  logic [4:0]         r_bit_cnt;
  logic [SW-1:0]      r_stall_cnt;
  logic [RW-1:0]      r_latch_cnt;
  logic               r_busy, r_underrun, r_frame_done;

  logic w_start_ok, w_xfer, w_load, w_pixel_end, w_stall_out, w_latch_end;
  logic w_bit_go, w_bit_end, w_line;

  // A start coinciding with frame_done is dropped even though the FSM is already back in IDLE.
  assign w_start_ok  = start && (r_state == ST_IDLE) && !r_frame_done;
  assign w_xfer      = pixel_valid && pixel_ready;
  assign w_pixel_end = (r_state == ST_SEND) && w_bit_end && (r_bit_cnt == 5'd0);
  assign w_load      = ((r_state == ST_FETCH) || w_pixel_end) && r_buf_full;
  assign w_stall_out = (r_state == ST_FETCH) && !r_buf_full && !w_xfer &&
                       (r_stall_cnt == SW'(STALL_MAX - 1));
  assign w_latch_end = (r_state == ST_LATCH) && (r_latch_cnt == RW'(RESET_CYC - 1));

  ws2812_bit_timer #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .BIT_CYC (BIT_CYC)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_go      (w_bit_go),
    .i_bit     (r_shifter[GRB_G_MSB]),
    .o_line    (w_line),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: each always_comb assigns a default first so no path leaves a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_next_state = ST_FETCH;
      ST_FETCH: begin
        if (r_buf_full)       w_next_state = ST_SEND;
        else if (w_stall_out) w_next_state = ST_LATCH;
      end
      ST_SEND: begin
        if (w_pixel_end && !r_buf_full)
          w_next_state = (r_sent_cnt < CNT_W'(NUM_LEDS)) ? ST_FETCH : ST_LATCH;
      end
      ST_LATCH: if (w_latch_end) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    pixel_ready = r_busy && !r_buf_full && (r_req_cnt < CNT_W'(NUM_LEDS)) &&
                  (r_state != ST_LATCH);
    w_bit_go    = (r_state == ST_SEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf        <= '0;
      r_shifter    <= '0;
      r_buf_full   <= 1'b0;
      r_req_cnt    <= '0;
      r_sent_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_stall_cnt  <= '0;
      r_latch_cnt  <= '0;
      r_busy       <= 1'b0;
      r_underrun   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_latch_end;
      if (w_latch_end) r_busy     <= 1'b0;
      if (w_stall_out) r_underrun <= 1'b1;

      if (w_load) r_buf_full <= 1'b0;
      if (w_xfer) begin
        r_buf      <= pixel_data;
        r_buf_full <= 1'b1;
        r_req_cnt  <= r_req_cnt + CNT_W'(1);
      end

      if (w_load) begin
        r_shifter  <= r_buf;
        r_bit_cnt  <= 5'd23;
        r_sent_cnt <= r_sent_cnt + CNT_W'(1);
      end else if ((r_state == ST_SEND) && w_bit_end) begin
        r_shifter <= r_shifter << 1;
        r_bit_cnt <= r_bit_cnt - 5'd1;
      end

      if (w_load)                                     r_stall_cnt <= '0;
      else if ((r_state == ST_FETCH) && !r_buf_full)  r_stall_cnt <= r_stall_cnt + SW'(1);

      if (r_state == ST_LATCH) r_latch_cnt <= r_latch_cnt + RW'(1);
      else                     r_latch_cnt <= '0;

      if (w_start_ok) begin
        r_busy      <= 1'b1;
        r_underrun  <= 1'b0;
        r_req_cnt   <= '0;
        r_sent_cnt  <= '0;
        r_stall_cnt <= '0;
        r_buf_full  <= 1'b0;
      end
    end
  end

  assign pixel_index = r_req_cnt[IW-1:0];
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign underrun    = r_underrun;
  assign leds_line   = w_line;

endmodule

// File: tb/tb_ws2812_frame_encoder.sv
// Directed bench for the WS2812 frame encoder with a 3-pixel frame and short timing,
// recording the line per cycle and decoding it back into pixels.
module tb_ws2812_frame_encoder;

  localparam int NUM_LEDS  = 3;
  localparam int T0H_CYC   = 2;
  localparam int T1H_CYC   = 4;
  localparam int BIT_CYC   = 6;
  localparam int RESET_CYC = 20;
  localparam int STALL_MAX = 10;
  localparam int PIX_CYC   = 24 * BIT_CYC;
  localparam int MAXS      = 700;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [1:0]  pixel_index;
  logic        busy, frame_done, underrun, leds_line;

  ws2812_frame_encoder #(
    .NUM_LEDS (NUM_LEDS), .T0H_CYC (T0H_CYC), .T1H_CYC (T1H_CYC),
    .BIT_CYC (BIT_CYC), .RESET_CYC (RESET_CYC), .STALL_MAX (STALL_MAX)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start),
    .pixel_data (pixel_data), .pixel_valid (pixel_valid), .pixel_ready (pixel_ready),
    .pixel_index (pixel_index), .busy (busy), .frame_done (frame_done),
    .underrun (underrun), .leds_line (leds_line)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [23:0] pix [3];
  int          hold [3];
  int          src_idx, src_age;
  bit          src_on, spam_on, s_fire;
  logic        line_h [MAXS];
  logic        busy_h [MAXS];
  logic        und_h  [MAXS];
  logic [7:0]  fire_idx [4];
  int          n, nf, ndone, done_at;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Source offers pixel src_idx once it has waited hold[src_idx] cycles since the last transfer.
  task automatic drive_src();
    if (src_on && src_idx < 3 && src_age >= hold[src_idx]) begin
      pixel_valid = 1'b1;
      pixel_data  = pix[src_idx];
    end else begin
      pixel_valid = 1'b0;
      pixel_data  = 24'h0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (n < MAXS) begin
      line_h[n] = leds_line;
      busy_h[n] = busy;
      und_h[n]  = underrun;
    end
    s_fire = pixel_valid && pixel_ready;
    if (s_fire) begin
      if (nf < 4) fire_idx[nf] = 8'(pixel_index);
      nf++;
    end
    if (frame_done) begin
      ndone++;
      if (done_at < 0) done_at = n;
      spam_on = 1'b0;
    end
    n++;
    @(posedge clk);
    #1;
    if (s_fire) begin
      src_idx++;
      src_age = 0;
    end else begin
      src_age++;
    end
    start = spam_on;
    drive_src();
  endtask

  task automatic clear_log();
    n = 0; nf = 0; ndone = 0; done_at = -1;
  endtask

  task automatic run_frame(input int h0, input int h1, input int h2, input bit spam);
    clear_log();
    hold[0] = h0; hold[1] = h1; hold[2] = h2;
    src_on  = 1'b0;
    spam_on = spam;
    start   = 1'b1;
    tick();
    src_on  = 1'b1;
    src_idx = 0;
    src_age = 0;
    drive_src();
    while (n < MAXS - 1 && (done_at < 0 || n < done_at + 4)) tick();
    src_on = 1'b0;
    start  = 1'b0;
    drive_src();
  endtask

  // Decodes npix pixels from the line log starting at the first high sample and
  // checks frame length, the low latch region and the end-of-frame flags.
  task automatic check_frame(input string tag, input int exp_first, input int npix,
                             input int exp_done, input logic exp_under);
    int          first, base, shape_err, hi;
    logic [23:0] got;
    bit          is1, is0;
    first = -1;
    for (int i = 0; i < n && i < MAXS; i++)
      if (first < 0 && line_h[i] === 1'b1) first = i;
    check({tag, "/first_high"}, first, exp_first);
    check({tag, "/done_at"}, done_at, exp_done);
    check({tag, "/done_pulses"}, ndone, 1);
    if (first >= 0) begin
      for (int p = 0; p < npix; p++) begin
        got = '0;
        shape_err = 0;
        for (int k = 0; k < 24; k++) begin
          base = first + (p * 24 + k) * BIT_CYC;
          is1 = 1'b1;
          is0 = 1'b1;
          for (int c = 0; c < BIT_CYC; c++) begin
            if (base + c >= MAXS || line_h[base + c] !== (c < T1H_CYC)) is1 = 1'b0;
            if (base + c >= MAXS || line_h[base + c] !== (c < T0H_CYC)) is0 = 1'b0;
          end
          if (!is1 && !is0) shape_err++;
          got = {got[22:0], is1};
        end
        check($sformatf("%s/pix%0d", tag, p), got, pix[p]);
        check($sformatf("%s/pix%0d_shape_errs", tag, p), shape_err, 0);
      end
    end
    if (first >= 0 && done_at > 0 && done_at < MAXS) begin
      hi = 0;
      for (int i = first + npix * PIX_CYC; i < done_at; i++) if (line_h[i] !== 1'b0) hi++;
      check({tag, "/latch_high_samples"}, hi, 0);
      check({tag, "/busy_before_done"}, busy_h[done_at - 1], 1'b1);
      check({tag, "/busy_at_done"}, busy_h[done_at], 1'b0);
      check({tag, "/underrun_at_done"}, und_h[done_at], exp_under);
    end
  endtask

  initial begin
    pix[0] = 24'hFF0000;
    pix[1] = 24'h00FF00;
    pix[2] = 24'h0000AA;
    src_on = 1'b0; spam_on = 1'b0; src_idx = 0; src_age = 0;
    hold[0] = 0; hold[1] = 0; hold[2] = 0;
    pixel_valid = 1'b0;
    pixel_data  = 24'h0;
    clear_log();

    // 1. reset, with start held high while in reset
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst/leds_line", leds_line, 1'b0);
    check("rst/pixel_ready", pixel_ready, 1'b0);
    check("rst/pixel_index", pixel_index, 2'd0);
    check("rst/busy", busy, 1'b0);
    check("rst/frame_done", frame_done, 1'b0);
    check("rst/underrun", underrun, 1'b0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    check("rst/busy_after_release", busy, 1'b0);

    // 2. plain frame: SEND starts 3 samples after the start sample, latch ends 432+20 later
    run_frame(0, 0, 0, 1'b0);
    check_frame("frame", 3, 3, 3 + 3 * PIX_CYC + RESET_CYC, 1'b0);

    // 3. first pixel offered 5 cycles late -> first high 5 samples later
    run_frame(5, 0, 0, 1'b0);
    check_frame("bp", 8, 3, 8 + 3 * PIX_CYC + RESET_CYC, 1'b0);

    // 4. last pixel withheld past the stall limit: FETCH 291..300, LATCH 301..320, done 321
    run_frame(0, 0, 400, 1'b0);
    check_frame("udr", 3, 2, 3 + 2 * PIX_CYC + STALL_MAX + RESET_CYC, 1'b1);
    check("udr/underrun_last_fetch", und_h[3 + 2 * PIX_CYC + STALL_MAX - 1], 1'b0);
    check("udr/underrun_first_latch", und_h[3 + 2 * PIX_CYC + STALL_MAX], 1'b1);
    check("udr/pixel_index", pixel_index, 2'd2);

    // 5. start held high for the whole frame, including the frame_done cycle
    run_frame(0, 0, 0, 1'b1);
    check_frame("spam", 3, 3, 3 + 3 * PIX_CYC + RESET_CYC, 1'b0);
    check("spam/transfers", nf, 3);
    check("spam/index0", fire_idx[0], 8'd0);
    check("spam/index1", fire_idx[1], 8'd1);
    check("spam/index2", fire_idx[2], 8'd2);
    if (done_at > 0 && done_at + 1 < MAXS)
      check("spam/no_restart", busy_h[done_at + 1], 1'b0);

    // 6. asynchronous reset while the line is high
    clear_log();
    hold[0] = 0; hold[1] = 0; hold[2] = 0;
    start = 1'b1;
    tick();
    src_on = 1'b1; src_idx = 0; src_age = 0;
    drive_src();
    for (int i = 0; i < 20 && leds_line !== 1'b1; i++) tick();
    check("arst/line_high_before", leds_line, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst/line_low", leds_line, 1'b0);
    check("arst/busy_low", busy, 1'b0);
    src_on = 1'b0;
    drive_src();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    repeat (8) tick();
    check("arst/no_done", ndone, 0);
    check("arst/idle_busy", busy, 1'b0);
    run_frame(0, 0, 0, 1'b0);
    check_frame("arst_frame", 3, 3, 3 + 3 * PIX_CYC + RESET_CYC, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
